// File: rtl/spi_byte_bridge.sv
// spi_byte_bridge: byte-level glue between a host and an spi_master.
// Host bytes queue in a TX FIFO and are handed to the SPI master one at a
// time; each returned byte is pushed into a first-word-fall-through RX FIFO.
module spi_byte_bridge #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             wr_data_i,
    input  logic                   wr_en_i,
    output logic                   tx_full_o,
    output logic [$clog2(DEPTH):0] tx_count_o,
    input  logic                   rd_en_i,
    output logic [7:0]             rd_data_o,
    output logic                   rx_empty_o,
    output logic [$clog2(DEPTH):0] rx_count_o,
    output logic                   rx_overflow_o,
    input  logic                   clr_i,
    output logic                   busy_o,
    output logic [7:0]             spi_tx_byte_o,
    output logic                   spi_tx_valid_o,
    input  logic                   spi_ready_i,
    input  logic [7:0]             spi_rx_byte_i,
    input  logic                   spi_rx_valid_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RX
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [CW-1:0] tx_count;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [CW-1:0] rx_count;

    logic [7:0]    tx_byte;
    logic          overflow;

    logic          tx_push;
    logic          tx_pop;
    logic          rx_pop;
    logic          rx_req;
    logic          rx_push;
    logic          rx_drop;

    // FIFO handshakes and FSM next-state decode
    always_comb begin
        tx_push   = wr_en_i && (tx_count != FULL);
        tx_pop    = (state == IDLE) && (tx_count != '0) && spi_ready_i;
        rx_pop    = rd_en_i && (rx_count != '0);
        rx_req    = (state == WAIT_RX) && spi_rx_valid_i;
        // a full RX FIFO still accepts the byte when the host pops in the same cycle
        rx_push   = rx_req && ((rx_count != FULL) || rx_pop);
        rx_drop   = rx_req && !rx_push;
        state_nxt = state;
        case (state)
            IDLE:    if (tx_pop) state_nxt = SEND;
            SEND:    state_nxt = WAIT_RX;
            WAIT_RX: if (spi_rx_valid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // TX FIFO pointers, occupancy and the byte presented to the SPI master
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            tx_byte  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop) begin
                tx_rptr <= tx_rptr + AW'(1);
                tx_byte <= tx_mem[tx_rptr];
            end
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= wr_data_i;
    end

    // RX FIFO pointers, occupancy and sticky overflow (set wins over clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            if (rx_drop)    overflow <= 1'b1;
            else if (clr_i) overflow <= 1'b0;
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= spi_rx_byte_i;
    end

    assign tx_full_o      = (tx_count == FULL);
    assign tx_count_o     = tx_count;
    assign rx_empty_o     = (rx_count == '0);
    assign rx_count_o     = rx_count;
    // head is forced to zero while empty so reset and drained states read 0x00
    assign rd_data_o      = (rx_count == '0) ? 8'h00 : rx_mem[rx_rptr];
    assign rx_overflow_o  = overflow;
    assign busy_o         = (state != IDLE) || (tx_count != '0);
    assign spi_tx_byte_o  = tx_byte;
    assign spi_tx_valid_o = (state == SEND);

endmodule

// File: tb/tb_spi_byte_bridge.sv
// Directed self-checking bench for spi_byte_bridge with a small SPI master
// responder that echoes each sent byte XOR 0x99 three cycles after SEND.
module tb_spi_byte_bridge;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wr_data_i;
    logic          wr_en_i;
    logic          tx_full_o;
    logic [CW-1:0] tx_count_o;
    logic          rd_en_i;
    logic [7:0]    rd_data_o;
    logic          rx_empty_o;
    logic [CW-1:0] rx_count_o;
    logic          rx_overflow_o;
    logic          clr_i;
    logic          busy_o;
    logic [7:0]    spi_tx_byte_o;
    logic          spi_tx_valid_o;
    logic          spi_ready_i;
    logic [7:0]    spi_rx_byte_i;
    logic          spi_rx_valid_i;

    int total = 0;
    int bad   = 0;

    spi_byte_bridge #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data_i     (wr_data_i),
        .wr_en_i       (wr_en_i),
        .tx_full_o     (tx_full_o),
        .tx_count_o    (tx_count_o),
        .rd_en_i       (rd_en_i),
        .rd_data_o     (rd_data_o),
        .rx_empty_o    (rx_empty_o),
        .rx_count_o    (rx_count_o),
        .rx_overflow_o (rx_overflow_o),
        .clr_i         (clr_i),
        .busy_o        (busy_o),
        .spi_tx_byte_o (spi_tx_byte_o),
        .spi_tx_valid_o(spi_tx_valid_o),
        .spi_ready_i   (spi_ready_i),
        .spi_rx_byte_i (spi_rx_byte_i),
        .spi_rx_valid_i(spi_rx_valid_i)
    );

    always #5 clk = ~clk;

    // reference model of the bridge occupancy and FSM
    typedef enum logic [1:0] {M_IDLE, M_SEND, M_WAIT} mst_t;
    mst_t       m_st;
    int         m_tx;
    int         m_rx;
    logic [7:0] m_txbyte;
    logic [7:0] txq [$];
    bit         resp_en;
    int         resp_cnt;

    task automatic model_reset();
        m_st     = M_IDLE;
        m_tx     = 0;
        m_rx     = 0;
        m_txbyte = 8'h00;
        resp_cnt = 0;
        txq.delete();
    endtask

    // advance one clock: update the model from current inputs, then let the responder react
    task automatic step();
        bit txpush, txpop, rxpop, rxreq, rxpush;
        txpush = wr_en_i && (m_tx < DEPTH);
        txpop  = (m_st == M_IDLE) && (m_tx > 0) && spi_ready_i;
        rxpop  = rd_en_i && (m_rx > 0);
        rxreq  = (m_st == M_WAIT) && spi_rx_valid_i;
        rxpush = rxreq && ((m_rx < DEPTH) || rxpop);
        if (txpop)  m_txbyte = txq.pop_front();
        if (txpush) txq.push_back(wr_data_i);
        m_tx = m_tx + int'(txpush) - int'(txpop);
        m_rx = m_rx + int'(rxpush) - int'(rxpop);
        case (m_st)
            M_IDLE:  if (txpop) m_st = M_SEND;
            M_SEND:  m_st = M_WAIT;
            default: if (spi_rx_valid_i) m_st = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        if (resp_en) begin
            spi_rx_valid_i = 1'b0;
            if (m_st == M_SEND) resp_cnt = 2;
            else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    spi_rx_valid_i = 1'b1;
                    spi_rx_byte_i  = m_txbyte ^ 8'h99;
                end
            end
        end
    endtask

    task automatic test_reset();
        total++; if (tx_count_o !== '0)       begin bad++; $display("FAIL reset_tx_count got=%0d exp=0", tx_count_o); end
        total++; if (rx_count_o !== '0)       begin bad++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count_o); end
        total++; if (tx_full_o !== 1'b0)      begin bad++; $display("FAIL reset_tx_full got=%b exp=0", tx_full_o); end
        total++; if (rx_empty_o !== 1'b1)     begin bad++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty_o); end
        total++; if (rx_overflow_o !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b exp=0", rx_overflow_o); end
        total++; if (spi_tx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", spi_tx_valid_o); end
        total++; if (spi_tx_byte_o !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%h exp=00", spi_tx_byte_o); end
        total++; if (rd_data_o !== 8'h00)     begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data_o); end
        total++; if (busy_o !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst = 1'b0;
        model_reset();
        step();
        total++; if (busy_o !== 1'b0)         begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_basic();
        spi_ready_i = 1'b1;
        resp_en     = 1'b1;
        wr_data_i   = 8'hA5;
        wr_en_i     = 1'b1;
        step();
        wr_en_i = 1'b0;
        total++; if (spi_tx_valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_n1 got=%b exp=0", spi_tx_valid_o); end
        total++; if (tx_count_o !== CW'(1))   begin bad++; $display("FAIL basic_tx_count got=%0d exp=1", tx_count_o); end
        total++; if (busy_o !== 1'b1)         begin bad++; $display("FAIL basic_busy got=%b exp=1", busy_o); end
        step();
        total++; if (spi_tx_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid_n2 got=%b exp=1", spi_tx_valid_o); end
        total++; if (spi_tx_byte_o !== 8'hA5) begin bad++; $display("FAIL basic_tx_byte got=%h exp=a5", spi_tx_byte_o); end
        total++; if (tx_count_o !== '0)       begin bad++; $display("FAIL basic_tx_drain got=%0d exp=0", tx_count_o); end
        step();
        total++; if (spi_tx_valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse got=%b exp=0", spi_tx_valid_o); end
        total++; if (spi_tx_byte_o !== 8'hA5) begin bad++; $display("FAIL basic_tx_hold got=%h exp=a5", spi_tx_byte_o); end
        for (int c = 0; c < 20 && rx_count_o == '0; c++) step();
        total++; if (rx_count_o !== CW'(1))   begin bad++; $display("FAIL basic_rx_count got=%0d exp=1", rx_count_o); end
        total++; if (rd_data_o !== 8'h3C)     begin bad++; $display("FAIL basic_rd_data got=%h exp=3c", rd_data_o); end
        total++; if (rx_empty_o !== 1'b0)     begin bad++; $display("FAIL basic_rx_empty got=%b exp=0", rx_empty_o); end
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        total++; if (rx_count_o !== '0)       begin bad++; $display("FAIL basic_pop_count got=%0d exp=0", rx_count_o); end
        total++; if (rx_empty_o !== 1'b1)     begin bad++; $display("FAIL basic_pop_empty got=%b exp=1", rx_empty_o); end
        total++; if (busy_o !== 1'b0)         begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_tx_full();
        int k;
        spi_ready_i = 1'b0;
        resp_en     = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            wr_data_i = 8'(8'h10 + i);
            wr_en_i   = 1'b1;
            step();
        end
        wr_en_i = 1'b0;
        total++; if (tx_full_o !== 1'b1)       begin bad++; $display("FAIL full_flag got=%b exp=1", tx_full_o); end
        total++; if (tx_count_o !== CW'(DEPTH)) begin bad++; $display("FAIL full_count got=%0d exp=%0d", tx_count_o, DEPTH); end
        total++; if (spi_tx_valid_o !== 1'b0)  begin bad++; $display("FAIL full_no_send got=%b exp=0", spi_tx_valid_o); end
        spi_ready_i = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < DEPTH; c++) begin
            step();
            if (spi_tx_valid_o === 1'b1) begin
                total++;
                if (spi_tx_byte_o !== 8'(8'h10 + k)) begin
                    bad++; $display("FAIL full_order idx=%0d got=%h exp=%h", k, spi_tx_byte_o, 8'(8'h10 + k));
                end
                k++;
            end
        end
        total++; if (k != DEPTH) begin bad++; $display("FAIL full_sent_count got=%0d exp=%0d", k, DEPTH); end
        for (int c = 0; c < 20 && rx_count_o != CW'(DEPTH); c++) step();
        repeat (8) step();
        total++; if (rx_count_o !== CW'(DEPTH)) begin bad++; $display("FAIL full_rx_count got=%0d exp=%0d", rx_count_o, DEPTH); end
        total++; if (tx_count_o !== '0)         begin bad++; $display("FAIL full_tx_empty got=%0d exp=0", tx_count_o); end
        total++; if (rx_overflow_o !== 1'b0)    begin bad++; $display("FAIL full_no_ovf got=%b exp=0", rx_overflow_o); end
        total++; if (rd_data_o !== 8'h89)       begin bad++; $display("FAIL full_rx_head got=%h exp=89", rd_data_o); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        wr_data_i = 8'h77;
        wr_en_i   = 1'b1;
        step();
        wr_en_i = 1'b0;
        repeat (8) step();
        total++; if (rx_overflow_o !== 1'b1)    begin bad++; $display("FAIL ovf_set got=%b exp=1", rx_overflow_o); end
        total++; if (rx_count_o !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", rx_count_o, DEPTH); end
        total++; if (rd_data_o !== 8'h89)       begin bad++; $display("FAIL ovf_head got=%h exp=89", rd_data_o); end
        total++; if (busy_o !== 1'b0)           begin bad++; $display("FAIL ovf_busy got=%b exp=0", busy_o); end
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        total++; if (rx_overflow_o !== 1'b0)    begin bad++; $display("FAIL ovf_clear got=%b exp=0", rx_overflow_o); end
        wr_data_i = 8'h78;
        wr_en_i   = 1'b1;
        step();
        wr_en_i = 1'b0;
        for (int c = 0; c < 20 && spi_rx_valid_i !== 1'b1; c++) step();
        total++; if (spi_rx_valid_i !== 1'b1)   begin bad++; $display("FAIL ovf_resp_timeout got=%b exp=1", spi_rx_valid_i); end
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        total++; if (rx_overflow_o !== 1'b0)    begin bad++; $display("FAIL ovf_poppush_flag got=%b exp=0", rx_overflow_o); end
        total++; if (rx_count_o !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_poppush_count got=%0d exp=%0d", rx_count_o, DEPTH); end
        for (int j = 0; j < DEPTH; j++) begin
            exp = (j < DEPTH - 1) ? (8'(8'h11 + j) ^ 8'h99) : 8'hE1;
            total++;
            if (rd_data_o !== exp) begin bad++; $display("FAIL ovf_drain idx=%0d got=%h exp=%h", j, rd_data_o, exp); end
            rd_en_i = 1'b1;
            step();
        end
        rd_en_i = 1'b0;
        total++; if (rx_empty_o !== 1'b1)       begin bad++; $display("FAIL ovf_drained got=%b exp=1", rx_empty_o); end
    endtask

    task automatic test_back_to_back();
        int wr_idx;
        int rd_idx;
        bit took;
        spi_ready_i = 1'b1;
        resp_en     = 1'b1;
        wr_idx      = 0;
        rd_idx      = 0;
        for (int c = 0; c < 3000 && rd_idx < 3 * DEPTH; c++) begin
            wr_en_i   = (wr_idx < 3 * DEPTH) && (m_tx < DEPTH);
            wr_data_i = 8'(8'hC0 + wr_idx);
            rd_en_i   = (m_rx > 0);
            took      = wr_en_i;
            if (rd_en_i) begin
                total++;
                if (rd_data_o !== (8'(8'hC0 + rd_idx) ^ 8'h99)) begin
                    bad++; $display("FAIL stream_order idx=%0d got=%h exp=%h", rd_idx, rd_data_o, 8'(8'hC0 + rd_idx) ^ 8'h99);
                end
                rd_idx++;
            end
            step();
            if (took) wr_idx++;
            total++; if (tx_count_o !== CW'(m_tx)) begin bad++; $display("FAIL stream_tx_count cyc=%0d got=%0d exp=%0d", c, tx_count_o, m_tx); end
            total++; if (rx_count_o !== CW'(m_rx)) begin bad++; $display("FAIL stream_rx_count cyc=%0d got=%0d exp=%0d", c, rx_count_o, m_rx); end
            total++; if (spi_tx_valid_o !== (m_st == M_SEND)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, spi_tx_valid_o, m_st == M_SEND); end
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        total++; if (rd_idx != 3 * DEPTH) begin bad++; $display("FAIL stream_done got=%0d exp=%0d", rd_idx, 3 * DEPTH); end
    endtask

    task automatic test_reset_midflight();
        spi_ready_i = 1'b1;
        resp_en     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data_i = 8'(8'h5A + i);
            wr_en_i   = 1'b1;
            step();
        end
        wr_en_i = 1'b0;
        for (int c = 0; c < 10 && m_st != M_WAIT; c++) step();
        resp_en        = 1'b0;
        spi_rx_valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (tx_count_o !== '0)       begin bad++; $display("FAIL arst_tx_count got=%0d exp=0", tx_count_o); end
        total++; if (busy_o !== 1'b0)         begin bad++; $display("FAIL arst_busy got=%b exp=0", busy_o); end
        total++; if (spi_tx_byte_o !== 8'h00) begin bad++; $display("FAIL arst_tx_byte got=%h exp=00", spi_tx_byte_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        spi_rx_valid_i = 1'b1;
        spi_rx_byte_i  = 8'h42;
        step();
        spi_rx_valid_i = 1'b0;
        step();
        total++; if (rx_count_o !== '0)       begin bad++; $display("FAIL arst_rx_count got=%0d exp=0", rx_count_o); end
        total++; if (rx_empty_o !== 1'b1)     begin bad++; $display("FAIL arst_rx_empty got=%b exp=1", rx_empty_o); end
        total++; if (rd_data_o !== 8'h00)     begin bad++; $display("FAIL arst_rd_data got=%h exp=00", rd_data_o); end
        total++; if (spi_tx_valid_o !== 1'b0) begin bad++; $display("FAIL arst_tx_valid got=%b exp=0", spi_tx_valid_o); end
        total++; if (tx_full_o !== 1'b0)      begin bad++; $display("FAIL arst_tx_full got=%b exp=0", tx_full_o); end
    endtask

    task automatic test_spurious();
        resp_en        = 1'b0;
        spi_rx_valid_i = 1'b1;
        spi_rx_byte_i  = 8'h55;
        step();
        spi_rx_valid_i = 1'b0;
        total++; if (rx_count_o !== '0)       begin bad++; $display("FAIL spur_rx_count got=%0d exp=0", rx_count_o); end
        total++; if (busy_o !== 1'b0)         begin bad++; $display("FAIL spur_busy got=%b exp=0", busy_o); end
        rd_en_i = 1'b1;
        step();
        step();
        rd_en_i = 1'b0;
        total++; if (rx_count_o !== '0)       begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", rx_count_o); end
        total++; if (rx_empty_o !== 1'b1)     begin bad++; $display("FAIL empty_pop_flag got=%b exp=1", rx_empty_o); end
        total++; if (rd_data_o !== 8'h00)     begin bad++; $display("FAIL empty_pop_data got=%h exp=00", rd_data_o); end
        total++; if (tx_count_o !== '0)       begin bad++; $display("FAIL spur_tx_count got=%0d exp=0", tx_count_o); end
        total++; if (spi_tx_valid_o !== 1'b0) begin bad++; $display("FAIL spur_tx_valid got=%b exp=0", spi_tx_valid_o); end
    endtask

    initial begin
        rst            = 1'b1;
        wr_data_i      = 8'h00;
        wr_en_i        = 1'b0;
        rd_en_i        = 1'b0;
        clr_i          = 1'b0;
        spi_ready_i    = 1'b0;
        spi_rx_byte_i  = 8'h00;
        spi_rx_valid_i = 1'b0;
        resp_en        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_tx_full();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/spi_byte_bridge.md
SPI_BYTE_BRIDGE -- requirements
Module: spi_byte_bridge

Interface
REQ-001 Parameter: DEPTH, 16, entries in each of the TX and RX FIFOs; power of two, 2..256.
REQ-002 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: wr_data_i  in  8  host byte to transmit.
REQ-005 Port: wr_en_i  in  1  host TX write strobe.
REQ-006 Port: tx_full_o  out  1  TX FIFO holds DEPTH entries.
REQ-007 Port: tx_count_o  out  $clog2(DEPTH)+1  TX FIFO occupancy.
REQ-008 Port: rd_en_i  in  1  host RX pop strobe.
REQ-009 Port: rd_data_o  out  8  RX FIFO head, first-word-fall-through.
REQ-010 Port: rx_empty_o  out  1  RX FIFO holds 0 entries.
REQ-011 Port: rx_count_o  out  $clog2(DEPTH)+1  RX FIFO occupancy.
REQ-012 Port: rx_overflow_o  out  1  sticky; a received byte was dropped.
REQ-013 Port: clr_i  in  1  synchronous clear of rx_overflow_o.
REQ-014 Port: busy_o  out  1  FSM not IDLE or TX FIFO non-empty.
REQ-015 Port: spi_tx_byte_o  out  8  byte to spi_master tx_byte_i.
REQ-016 Port: spi_tx_valid_o  out  1  to spi_master tx_byte_valid_i.
REQ-017 Port: spi_ready_i  in  1  from spi_master ready_o.
REQ-018 Port: spi_rx_byte_i  in  8  from spi_master rx_byte_o.
REQ-019 Port: spi_rx_valid_i  in  1  from spi_master rx_byte_valid_o (1-cycle pulse).

Function
REQ-020 TX write accepted iff wr_en_i=1 and tx_full_o=0 in that cycle; otherwise discarded, no state change.
REQ-021 FSM states IDLE, SEND, WAIT_RX; reset state IDLE.
REQ-022 IDLE -> SEND when tx_count_o>0 and spi_ready_i=1; on that edge pop TX head into spi_tx_byte_o.
REQ-023 SEND lasts exactly one cycle, spi_tx_valid_o=1 only in SEND; SEND -> WAIT_RX unconditionally.
REQ-024 WAIT_RX -> IDLE on spi_rx_valid_i=1, pushing spi_rx_byte_i into RX FIFO per REQ-026/027.
REQ-025 spi_rx_valid_i in IDLE or SEND ignored; no push.
REQ-026 RX push accepted if RX count<DEPTH, or count=DEPTH and rd_en_i=1 same cycle (pop then push, count unchanged).
REQ-027 RX push refused when full without same-cycle pop: byte dropped, rx_overflow_o set to 1 next cycle.
REQ-028 rx_overflow_o held until clr_i=1; set has priority over clr_i in the same cycle.
REQ-029 rd_en_i with rx_empty_o=1 ignored; rd_data_o shows new head the cycle after a pop.
REQ-030 Simultaneous host write and internal pop on TX FIFO: both performed, count unchanged.
REQ-031 Latency: byte written at edge N (TX FIFO empty, FSM IDLE, spi_ready_i=1) -> spi_tx_valid_o=1 in cycle N+2.
REQ-032 Pointers wrap modulo DEPTH; counts range 0..DEPTH inclusive, never exceed DEPTH.
REQ-033 spi_tx_byte_o holds its value from SEND until next SEND.

Reset
REQ-034 On rst=1: FSM IDLE, both FIFOs empty, pointers 0, tx_count_o=0, rx_count_o=0, tx_full_o=0, rx_empty_o=1, rx_overflow_o=0, spi_tx_valid_o=0, spi_tx_byte_o=0x00, rd_data_o=0x00, busy_o=0.
REQ-035 Reset mid-transfer discards FIFO contents and in-flight byte; a later spi_rx_valid_i in IDLE is ignored.

Verification
REQ-036 Write 0xA5, spi_ready_i=1 -> spi_tx_valid_o pulse 1 cycle at N+2 with 0xA5; model returns 0x3C -> rx_count_o=1, rd_data_o=0x3C.
REQ-037 Write DEPTH+1 bytes with spi_ready_i=0 -> tx_full_o=1, tx_count_o=DEPTH, extra byte lost; release ready -> DEPTH bytes sent in order.
REQ-038 Fill RX to DEPTH, no reads, one more transfer -> byte dropped, rx_overflow_o=1; clr_i -> 0; repeat with rd_en_i in push cycle -> no overflow, count=DEPTH.
REQ-039 Continuous writes/reads of 3*DEPTH bytes -> order preserved across pointer wrap, counts correct each cycle.
REQ-040 rst asserted in WAIT_RX then spi_rx_valid_i pulse -> all outputs at reset values, rx_count_o=0.
REQ-041 Spurious spi_rx_valid_i in IDLE; rd_en_i on empty RX -> no state change.
